keypad_entry_ctrl: RTL and testbench

//  Downstream of the row-scanning keypad decoder. Takes its per-cycle key code and hit strobes,

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_entry_ctrl_if.sv | 25 ++
 rtl/keypad_debounce_fsm.sv | 145 ++++++++++++++
 rtl/keypad_entry_ctrl.sv | 82 ++++++++
 tb/tb_keypad_entry_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state and frame-class encodings for the keypad entry controller.
package keypad_pkg;

   localparam logic [3:0] KEY_CLEAR     = 4'hc;
   localparam logic [3:0] KEY_ENTER     = 4'he;
   localparam logic [3:0] KEY_BACK      = 4'hf;
   localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CAND = 2'd1,
      ST_HELD = 2'd2
   } fsm_state_t;

   typedef enum logic [1:0] {
      FR_EMPTY = 2'd0,
      FR_KEY   = 2'd1,
      FR_MULTI = 2'd2
   } frame_class_t;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= KEY_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Scanner-side inputs and entry-side outputs of the keypad entry controller.
interface keypad_entry_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  key_hit;
   logic [3:0]            key_code;
   logic                  frame_end;
   logic                  key_valid;
   logic [3:0]            key_out;
   logic [4*DIGITS-1:0]   digits_out;
   logic [2:0]            digit_count;
   logic [4*DIGITS-1:0]   entry_value;
   logic                  entry_done;
   logic                  busy;

   modport master (
      output key_hit, key_code, frame_end,
      input  key_valid, key_out, digits_out, digit_count, entry_value, entry_done, busy
   );

   modport slave (
      input  key_hit, key_code, frame_end,
      output key_valid, key_out, digits_out, digit_count, entry_value, entry_done, busy
   );
endinterface

// File: rtl/keypad_debounce_fsm.sv
// Per-frame key classification and press/release debounce.
//  state | meaning
//  IDLE  | no key being tracked
//  CAND  | same key seen in r_cnt consecutive frames, not yet accepted
//  HELD  | key accepted; waiting for DEBOUNCE_FRAMES empty frames
module keypad_debounce_fsm
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_key_hit,
   input  logic [3:0] i_key_code,
   input  logic       i_frame_end,
   output logic       o_key_valid,
   output logic [3:0] o_key_out,
   output logic       o_busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_seen;
   logic             r_multi;
   logic [3:0]       r_code;

   fsm_state_t       r_state, w_state_nxt;
   logic [3:0]       r_cand, w_cand_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_rel, w_rel_nxt;
   logic             r_key_valid, w_key_valid_nxt;
   logic [3:0]       r_key_out, w_key_out_nxt;

   logic             w_any;
   logic             w_multi;
   logic [3:0]       w_code;
   frame_class_t     w_class;

   // The frame_end cycle itself belongs to the frame being closed.
   assign w_any   = r_seen | i_key_hit;
   assign w_code  = r_seen ? r_code : i_key_code;
   assign w_multi = r_multi | (r_seen & i_key_hit & (i_key_code != r_code));

   always_comb begin
      w_class = FR_EMPTY;
      if (w_multi)    w_class = FR_MULTI;
      else if (w_any) w_class = FR_KEY;
   end

   always_ff @(posedge clk) begin
      if (!reset || i_frame_end) begin
         r_seen  <= 1'b0;
         r_multi <= 1'b0;
         r_code  <= 4'h0;
      end else if (i_key_hit) begin
         if (!r_seen) begin
            r_seen <= 1'b1;
            r_code <= i_key_code;
         end else if (i_key_code != r_code) begin
            r_multi <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cand      <= 4'h0;
         r_cnt       <= '0;
         r_rel       <= '0;
         r_key_valid <= 1'b0;
         r_key_out   <= 4'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_cand      <= w_cand_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rel       <= w_rel_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_key_out   <= w_key_out_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cand_nxt      = r_cand;
      w_cnt_nxt       = r_cnt;
      w_rel_nxt       = r_rel;
      w_key_valid_nxt = 1'b0;
      w_key_out_nxt   = r_key_out;
      if (i_frame_end) begin
         case (r_state)
            ST_IDLE: begin
               if (w_class == FR_KEY) begin
                  w_state_nxt = ST_CAND;
                  w_cand_nxt  = w_code;
                  w_cnt_nxt   = CNT_ONE;
               end
            end
            ST_CAND: begin
               if (w_class == FR_KEY && w_code == r_cand) begin
                  if (r_cnt == CNT_LAST) begin
                     w_state_nxt     = ST_HELD;
                     w_key_valid_nxt = 1'b1;
                     w_key_out_nxt   = r_cand;
                     w_cnt_nxt       = '0;
                     w_rel_nxt       = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_ONE;
                  end
               end else if (w_class == FR_KEY) begin
                  w_cand_nxt = w_code;
                  w_cnt_nxt  = CNT_ONE;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            ST_HELD: begin
               if (w_class == FR_EMPTY) begin
                  if (r_rel == CNT_LAST) begin
                     w_state_nxt = ST_IDLE;
                     w_rel_nxt   = '0;
                  end else begin
                     w_rel_nxt = r_rel + CNT_ONE;
                  end
               end else begin
                  w_rel_nxt = '0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_rel_nxt   = '0;
            end
         endcase
      end
   end

   assign o_key_valid = r_key_valid;
   assign o_key_out   = r_key_out;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key accept plus a BCD digit-entry buffer with
// clear, backspace and enter.
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int DIGITS          = 4,
   parameter int CNT_W           = 3
) (
   input  logic               clk,
   input  logic               reset,
   keypad_entry_ctrl_if.slave kp
);

   localparam int           BUF_W      = 4 * DIGITS;
   localparam logic [2:0]   DIGITS_MAX = 3'(DIGITS);

   logic             w_key_valid;
   logic [3:0]       w_key_out;
   logic             w_busy;

   logic [BUF_W-1:0] r_buf;
   logic [2:0]       r_count;
   logic [BUF_W-1:0] r_entry_value;
   logic             r_entry_done;

   keypad_debounce_fsm #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .i_key_hit   (kp.key_hit),
      .i_key_code  (kp.key_code),
      .i_frame_end (kp.frame_end),
      .o_key_valid (w_key_valid),
      .o_key_out   (w_key_out),
      .o_busy      (w_busy)
   );

   // Acts on the edge that ends the key_valid cycle; A, B, D fall through untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_buf         <= '0;
         r_count       <= 3'd0;
         r_entry_value <= '0;
         r_entry_done  <= 1'b0;
      end else begin
         r_entry_done <= 1'b0;
         if (w_key_valid) begin
            if (is_digit(w_key_out)) begin
               if (r_count < DIGITS_MAX) begin
                  r_buf   <= {r_buf[BUF_W-5:0], w_key_out};
                  r_count <= r_count + 3'd1;
               end
            end else if (w_key_out == KEY_CLEAR) begin
               r_buf   <= '0;
               r_count <= 3'd0;
            end else if (w_key_out == KEY_BACK) begin
               if (r_count != 3'd0) begin
                  r_buf   <= {4'h0, r_buf[BUF_W-1:4]};
                  r_count <= r_count - 3'd1;
               end
            end else if (w_key_out == KEY_ENTER) begin
               r_entry_value <= r_buf;
               r_entry_done  <= 1'b1;
               r_buf         <= '0;
               r_count       <= 3'd0;
            end
         end
      end
   end

   assign kp.key_valid   = w_key_valid;
   assign kp.key_out     = w_key_out;
   assign kp.busy        = w_busy;
   assign kp.digits_out  = r_buf;
   assign kp.digit_count = r_count;
   assign kp.entry_value = r_entry_value;
   assign kp.entry_done  = r_entry_done;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with DEBOUNCE_FRAMES=4, DIGITS=4.
module tb_keypad_entry_ctrl;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   n_kv;
   int   kv_snap;

   keypad_entry_ctrl_if #(.DIGITS(4)) kp ();

   keypad_entry_ctrl #(
      .DEBOUNCE_FRAMES (4),
      .DIGITS          (4),
      .CNT_W           (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial n_kv = 0;
   always @(negedge clk) if (kp.key_valid === 1'b1) n_kv = n_kv + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         kp.key_hit   = 1'b0;
         kp.key_code  = 4'h0;
         kp.frame_end = 1'b0;
      end
   endtask

   // 4-cycle frame: code a with hit_a on cycles 0-1, code b with hit_b on cycles 2-3.
   task automatic run_frame(input logic [3:0] a, input logic [3:0] b, input bit hit_a, input bit hit_b);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         kp.key_hit   = (i < 2) ? hit_a : hit_b;
         kp.key_code  = (i < 2) ? a : b;
         kp.frame_end = (i == 3);
      end
   endtask

   task automatic key_frames(input logic [3:0] c, input int n);
      for (int i = 0; i < n; i++) run_frame(c, c, 1'b1, 1'b1);
   endtask

   task automatic empty_frames(input int n);
      for (int i = 0; i < n; i++) run_frame(4'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic press(input logic [3:0] c);
      key_frames(c, 4);
      empty_frames(4);
      idle(2);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      kp.key_hit = 1'b0;
      kp.key_code = 4'h0;
      kp.frame_end = 1'b0;
      idle(3);
      chk("rst_key_valid", 32'(kp.key_valid), 32'd0);
      chk("rst_key_out", 32'(kp.key_out), 32'h0);
      chk("rst_digits", 32'(kp.digits_out), 32'h0);
      chk("rst_count", 32'(kp.digit_count), 32'd0);
      chk("rst_entry_value", 32'(kp.entry_value), 32'h0);
      chk("rst_entry_done", 32'(kp.entry_done), 32'd0);
      chk("rst_busy", 32'(kp.busy), 32'd0);
      reset = 1'b1;
      idle(2);

      // Key 5 held 4 frames: accept one cycle after the 4th frame_end.
      kv_snap = n_kv;
      key_frames(4'h5, 3);
      idle(1);
      chk("k5_busy_cand", 32'(kp.busy), 32'd1);
      chk("k5_no_early_valid", 32'(kp.key_valid), 32'd0);
      key_frames(4'h5, 1);
      idle(1);
      chk("k5_valid", 32'(kp.key_valid), 32'd1);
      chk("k5_key_out", 32'(kp.key_out), 32'h5);
      chk("k5_digits_not_yet", 32'(kp.digits_out), 32'h0);
      idle(1);
      chk("k5_valid_drop", 32'(kp.key_valid), 32'd0);
      chk("k5_digits", 32'(kp.digits_out), 32'h0005);
      chk("k5_count", 32'(kp.digit_count), 32'd1);
      empty_frames(4);
      idle(1);
      chk("k5_released", 32'(kp.busy), 32'd0);
      chk("k5_pulses", 32'(n_kv - kv_snap), 32'd1);

      // 3 frames then a gap: dropped.
      kv_snap = n_kv;
      key_frames(4'h5, 3);
      empty_frames(1);
      idle(1);
      chk("short_idle", 32'(kp.busy), 32'd0);
      key_frames(4'h5, 1);
      idle(3);
      chk("short_restart_cand", 32'(kp.busy), 32'd1);
      empty_frames(1);
      idle(1);
      chk("short_pulses", 32'(n_kv - kv_snap), 32'd0);
      chk("short_digits", 32'(kp.digits_out), 32'h0005);

      // Hold 7 for 20 frames: one accept, no repeat; 3 empty + hit keeps HELD.
      kv_snap = n_kv;
      key_frames(4'h7, 20);
      empty_frames(3);
      key_frames(4'h7, 1);
      idle(1);
      chk("hold_still_held", 32'(kp.busy), 32'd1);
      empty_frames(3);
      idle(1);
      chk("hold_3_empty_held", 32'(kp.busy), 32'd1);
      empty_frames(1);
      idle(1);
      chk("hold_released", 32'(kp.busy), 32'd0);
      chk("hold_pulses", 32'(n_kv - kv_snap), 32'd1);
      chk("hold_digits", 32'(kp.digits_out), 32'h0057);
      chk("hold_count", 32'(kp.digit_count), 32'd2);

      press(4'hc);
      chk("clear_digits", 32'(kp.digits_out), 32'h0);
      chk("clear_count", 32'(kp.digit_count), 32'd0);

      press(4'h1);
      press(4'h2);
      press(4'h3);
      press(4'h4);
      press(4'h9);
      chk("full_digits", 32'(kp.digits_out), 32'h1234);
      chk("full_count", 32'(kp.digit_count), 32'd4);
      chk("full_key_out", 32'(kp.key_out), 32'h9);
      press(4'hf);
      chk("back_digits", 32'(kp.digits_out), 32'h0123);
      chk("back_count", 32'(kp.digit_count), 32'd3);

      press(4'hc);
      press(4'hf);
      chk("back_empty_digits", 32'(kp.digits_out), 32'h0);
      chk("back_empty_count", 32'(kp.digit_count), 32'd0);

      // Enter with 4,2 in the buffer.
      press(4'h4);
      press(4'h2);
      key_frames(4'he, 4);
      idle(1);
      chk("ent_valid", 32'(kp.key_valid), 32'd1);
      chk("ent_done_not_yet", 32'(kp.entry_done), 32'd0);
      idle(1);
      chk("ent_done", 32'(kp.entry_done), 32'd1);
      chk("ent_value", 32'(kp.entry_value), 32'h0042);
      chk("ent_digits_clr", 32'(kp.digits_out), 32'h0);
      chk("ent_count_clr", 32'(kp.digit_count), 32'd0);
      idle(1);
      chk("ent_done_drop", 32'(kp.entry_done), 32'd0);
      chk("ent_value_held", 32'(kp.entry_value), 32'h0042);
      empty_frames(4);
      idle(2);

      // A pulses key_valid but leaves the buffer alone.
      kv_snap = n_kv;
      press(4'h8);
      press(4'ha);
      chk("a_pulses", 32'(n_kv - kv_snap), 32'd2);
      chk("a_key_out", 32'(kp.key_out), 32'ha);
      chk("a_digits", 32'(kp.digits_out), 32'h0008);
      chk("a_count", 32'(kp.digit_count), 32'd1);

      // Two codes in one frame: MULTI never accepts.
      kv_snap = n_kv;
      for (int i = 0; i < 4; i++) run_frame(4'h3, 4'h6, 1'b1, 1'b1);
      idle(1);
      chk("multi_idle", 32'(kp.busy), 32'd0);
      key_frames(4'h3, 1);
      idle(1);
      chk("multi_cand", 32'(kp.busy), 32'd1);
      run_frame(4'h3, 4'h6, 1'b1, 1'b1);
      idle(1);
      chk("multi_drop_cand", 32'(kp.busy), 32'd0);
      chk("multi_pulses", 32'(n_kv - kv_snap), 32'd0);

      // Hits only in the frame_end cycle's half still count for that frame.
      kv_snap = n_kv;
      for (int i = 0; i < 4; i++) run_frame(4'h0, 4'h6, 1'b0, 1'b1);
      idle(1);
      chk("late_hit_valid", 32'(kp.key_valid), 32'd1);
      chk("late_hit_key", 32'(kp.key_out), 32'h6);
      empty_frames(4);
      idle(2);
      chk("late_hit_digits", 32'(kp.digits_out), 32'h0086);

      // Reset in the middle of a candidate press drops it.
      kv_snap = n_kv;
      key_frames(4'h1, 2);
      idle(1);
      chk("mid_cand_busy", 32'(kp.busy), 32'd1);
      reset = 1'b0;
      idle(2);
      chk("mid_rst_busy", 32'(kp.busy), 32'd0);
      chk("mid_rst_key_out", 32'(kp.key_out), 32'h0);
      chk("mid_rst_digits", 32'(kp.digits_out), 32'h0);
      chk("mid_rst_count", 32'(kp.digit_count), 32'd0);
      chk("mid_rst_entry_value", 32'(kp.entry_value), 32'h0);
      reset = 1'b1;
      idle(1);
      key_frames(4'h1, 2);
      idle(1);
      chk("post_rst_no_accept", 32'(n_kv - kv_snap), 32'd0);
      chk("post_rst_cand", 32'(kp.busy), 32'd1);
      key_frames(4'h1, 2);
      idle(1);
      chk("post_rst_accept", 32'(kp.key_valid), 32'd1);
      idle(1);
      chk("post_rst_digits", 32'(kp.digits_out), 32'h0001);
      empty_frames(4);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
